// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port synchronous Data_Memory between the CPU datapath and
// the UART debug unit. The CPU has priority. A starvation counter forces debug
// through after STARVE_MAX consecutive CPU wins while a debug request waits.
// The CPU is stalled in any cycle it loses the port.
//
// Optional feature macro: DMEM_ARB_BURST_EN
//   defined   : dbg_lock keeps debug ownership across a burst of accesses
//   undefined : dbg_lock is ignored and no lock register exists
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_cpu_rd/_wr/_addr/_wdata      CPU request (a write wins if rd and wr are both high)
//   o_cpu_rdata                    read data to the datapath (mem read data, combinational)
//   o_cpu_stall                    CPU lost arbitration this cycle
//   i_dbg_req/_we/_addr/_wdata     debug request, held stable until granted
//   i_dbg_lock                     hold debug ownership (burst builds only)
//   o_dbg_gnt                      debug access accepted this cycle
//   o_dbg_rvalid, o_dbg_rdata      debug read return, one cycle after the grant
//   o_mem_rd/_wr/_addr/_wdata      Data_Memory request
//   i_mem_rdata                    Data_Memory read data (one cycle after the read)

module dmem_arbiter #(
   parameter int unsigned AB         = 11,
   parameter int unsigned DB         = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_cpu_rd,
   input  logic          i_cpu_wr,
   input  logic [AB-1:0] i_cpu_addr,
   input  logic [DB-1:0] i_cpu_wdata,
   output logic [DB-1:0] o_cpu_rdata,
   output logic          o_cpu_stall,
   input  logic          i_dbg_req,
   input  logic          i_dbg_we,
   input  logic [AB-1:0] i_dbg_addr,
   input  logic [DB-1:0] i_dbg_wdata,
   input  logic          i_dbg_lock,
   output logic          o_dbg_gnt,
   output logic          o_dbg_rvalid,
   output logic [DB-1:0] o_dbg_rdata,
   output logic          o_mem_rd,
   output logic          o_mem_wr,
   output logic [AB-1:0] o_mem_addr,
   output logic [DB-1:0] o_mem_wdata,
   input  logic [DB-1:0] i_mem_rdata
);

   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   logic          r_rvalid;
   logic [DB-1:0] r_rdata;
   logic [3:0]    r_starve_cnt;
   logic [3:0]    w_starve_cnt_d;
   logic          w_cpu_act;
   logic          w_starved;
   logic          w_locked;
   logic          w_dbg_win;

   assign w_cpu_act = i_cpu_rd | i_cpu_wr;
   assign w_starved = (r_starve_cnt == StarveMax);

`ifdef DMEM_ARB_BURST_EN
   logic r_lock;

   // Lock drops as soon as the requester releases dbg_lock or dbg_req.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lock <= 1'b0;
      end else if (!i_dbg_lock || !i_dbg_req) begin
         r_lock <= 1'b0;
      end else if (o_dbg_gnt) begin
         r_lock <= 1'b1;
      end
   end

   assign w_locked = r_lock;
`else
   logic w_unused_lock;

   assign w_unused_lock = i_dbg_lock;
   assign w_locked      = 1'b0;
`endif

   assign w_dbg_win = i_dbg_req & (~w_cpu_act | w_starved | w_locked);

   // Port steering; idle drives zeros on the memory bus.
   always_comb begin
      o_mem_rd    = 1'b0;
      o_mem_wr    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_dbg_gnt   = 1'b0;
      o_cpu_stall = 1'b0;
      if (w_dbg_win) begin
         o_dbg_gnt   = 1'b1;
         o_mem_wr    = i_dbg_we;
         o_mem_rd    = ~i_dbg_we;
         o_mem_addr  = i_dbg_addr;
         o_mem_wdata = i_dbg_wdata;
         o_cpu_stall = w_cpu_act;
      end else if (w_cpu_act) begin
         o_mem_wr    = i_cpu_wr;
         o_mem_rd    = ~i_cpu_wr;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
      end
   end

   // Counts CPU wins against a pending debug request; saturates at the limit.
   always_comb begin
      w_starve_cnt_d = r_starve_cnt;
      if (!i_dbg_req || w_dbg_win) begin
         w_starve_cnt_d = '0;
      end else if (r_starve_cnt < StarveMax) begin
         w_starve_cnt_d = r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_starve_cnt <= '0;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_starve_cnt <= w_starve_cnt_d;
         r_rvalid     <= w_dbg_win & ~i_dbg_we;
         if (r_rvalid) begin
            r_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_cpu_rdata = i_mem_rdata;

   // Memory data only arrives in the return cycle, so it is forwarded while
   // rvalid is high and the captured copy is shown afterwards. Reset masks
   // both so a read granted just before reset never returns.
   assign o_dbg_rvalid = r_rvalid & ~i_reset;
   assign o_dbg_rdata  = i_reset  ? '0 :
                         r_rvalid ? i_mem_rdata : r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr;
   logic [10:0] cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req, dbg_we, dbg_lock;
   logic [10:0] dbg_addr;
   logic [15:0] dbg_wdata;
   logic        dbg_gnt, dbg_rvalid;
   logic [15:0] dbg_rdata;
   logic        mem_rd, mem_wr;
   logic [10:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   logic [15:0] mem [0:2047];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AB(11), .DB(16), .STARVE_MAX(4)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_cpu_rd    (cpu_rd),
      .i_cpu_wr    (cpu_wr),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .o_cpu_rdata (cpu_rdata),
      .o_cpu_stall (cpu_stall),
      .i_dbg_req   (dbg_req),
      .i_dbg_we    (dbg_we),
      .i_dbg_addr  (dbg_addr),
      .i_dbg_wdata (dbg_wdata),
      .i_dbg_lock  (dbg_lock),
      .o_dbg_gnt   (dbg_gnt),
      .o_dbg_rvalid(dbg_rvalid),
      .o_dbg_rdata (dbg_rdata),
      .o_mem_rd    (mem_rd),
      .o_mem_wr    (mem_wr),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   // Synchronous single-port memory environment.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   // Scoreboard: every debug read return must match the oldest expectation.
   always @(negedge clk) begin
      if (dbg_rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%h, required no return", dbg_rdata);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (dbg_rdata !== e) begin
               errors++;
               $display("FAIL sb_rdata: got %h, required %h", dbg_rdata, e);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
      mem_rdata = '0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      next_cycle();
      #2;
      checks += 6;
      if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b, required 0", mem_rd); end
      if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr: got %b, required 0", mem_wr); end
      if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b, required 0", dbg_rvalid); end
      if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h, required 0000", dbg_rdata); end
      if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b, required 0", cpu_stall); end
      if (mem_addr !== 11'h0) begin errors++; $display("FAIL rst_mem_addr: got %h, required 000", mem_addr); end
   endtask

   task automatic test_cpu_write_dbg_read();
      next_cycle();
      cpu_wr = 1; cpu_addr = 11'h005; cpu_wdata = 16'h1234;
      #2;
      checks += 4;
      if (mem_wr !== 1'b1) begin errors++; $display("FAIL wr_mem_wr: got %b, required 1", mem_wr); end
      if (mem_rd !== 1'b0) begin errors++; $display("FAIL wr_mem_rd: got %b, required 0", mem_rd); end
      if (mem_addr !== 11'h005) begin errors++; $display("FAIL wr_mem_addr: got %h, required 005", mem_addr); end
      if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL wr_mem_wdata: got %h, required 1234", mem_wdata); end
      next_cycle();
      cpu_wr = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 11'h005;
      #2;
      checks += 4;
      if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b, required 1", dbg_gnt); end
      if (mem_rd !== 1'b1) begin errors++; $display("FAIL rd_mem_rd: got %b, required 1", mem_rd); end
      if (mem_addr !== 11'h005) begin errors++; $display("FAIL rd_mem_addr: got %h, required 005", mem_addr); end
      if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall: got %b, required 0", cpu_stall); end
      if (dbg_gnt) exp_q.push_back(16'h1234);
      next_cycle();
      dbg_req = 0;
      #2;
      checks += 2;
      if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b, required 1", dbg_rvalid); end
      if (dbg_rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h, required 1234", dbg_rdata); end
      next_cycle();
      #2;
      checks += 2;
      if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b, required 0", dbg_rvalid); end
      if (dbg_rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata_hold: got %h, required 1234", dbg_rdata); end
   endtask

   task automatic test_starvation();
      int n;
      bit got;
      next_cycle();
      cpu_wr = 1; cpu_addr = 11'h010; cpu_wdata = 16'hBEEF;
      next_cycle();
      cpu_wr = 0; cpu_rd = 1; cpu_addr = 11'h020;
      dbg_req = 1; dbg_we = 0; dbg_addr = 11'h010;
      for (int c = 1; c <= 4; c++) begin
         #2;
         checks += 3;
         if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL starve_gnt_c%0d: got %b, required 0", c, dbg_gnt); end
         if (cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_stall_c%0d: got %b, required 0", c, cpu_stall); end
         if (mem_addr !== 11'h020) begin errors++; $display("FAIL starve_addr_c%0d: got %h, required 020", c, mem_addr); end
         next_cycle();
      end
      #2;
      checks += 3;
      if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL starve_gnt_c5: got %b, required 1", dbg_gnt); end
      if (cpu_stall !== 1'b1) begin errors++; $display("FAIL starve_stall_c5: got %b, required 1", cpu_stall); end
      if (mem_addr !== 11'h010) begin errors++; $display("FAIL starve_addr_c5: got %h, required 010", mem_addr); end
      if (dbg_gnt) exp_q.push_back(16'hBEEF);
      // A fresh request must wait the full limit again: the counter was cleared.
      next_cycle();
      n = 0; got = 0;
      while (!got && n < 20) begin
         n++;
         #2;
         if (dbg_gnt) begin
            got = 1;
            exp_q.push_back(16'hBEEF);
         end
         next_cycle();
      end
      dbg_req = 0; cpu_rd = 0;
      checks++;
      if (!got || n != 5) begin errors++; $display("FAIL starve_regrant: got wait=%0d granted=%0b, required wait=5 granted=1", n, got); end
      next_cycle();
   endtask

   task automatic test_rw_both();
      cpu_rd = 1; cpu_wr = 1; cpu_addr = 11'h7FF; cpu_wdata = 16'h5A5A;
      #2;
      checks += 3;
      if (mem_wr !== 1'b1) begin errors++; $display("FAIL both_mem_wr: got %b, required 1", mem_wr); end
      if (mem_rd !== 1'b0) begin errors++; $display("FAIL both_mem_rd: got %b, required 0", mem_rd); end
      if (mem_addr !== 11'h7FF) begin errors++; $display("FAIL both_mem_addr: got %h, required 7ff", mem_addr); end
      next_cycle();
      cpu_rd = 0; cpu_wr = 0;
      next_cycle();
   endtask

   task automatic test_burst();
      int n;
      bit got;
      int exp_wait;
      cpu_rd = 1; cpu_addr = 11'h020;
      dbg_lock = 1;
      for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_BURST_EN
         exp_wait = (k == 0) ? 5 : 1;
`else
         exp_wait = 5;
`endif
         dbg_req = 1; dbg_we = 1; dbg_addr = 11'h100 + 11'(k); dbg_wdata = 16'hA000 + 16'(k);
         n = 0; got = 0;
         while (!got && n < 20) begin
            n++;
            #2;
            if (dbg_gnt) begin
               got = 1;
               checks++;
               if (cpu_stall !== 1'b1) begin errors++; $display("FAIL burst_stall_%0d: got %b, required 1", k, cpu_stall); end
            end
            next_cycle();
         end
         checks++;
         if (!got || n != exp_wait) begin
            errors++;
            $display("FAIL burst_wait_%0d: got wait=%0d granted=%0b, required wait=%0d granted=1", k, n, got, exp_wait);
         end
      end
      dbg_req = 0; dbg_we = 0; dbg_lock = 0; cpu_rd = 0;
      next_cycle();
      // Read the burst back through debug with the CPU idle.
      for (int k = 0; k < 3; k++) begin
         dbg_req = 1; dbg_we = 0; dbg_addr = 11'h100 + 11'(k);
         #2;
         checks++;
         if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL readback_gnt_%0d: got %b, required 1", k, dbg_gnt); end
         else exp_q.push_back(16'hA000 + 16'(k));
         next_cycle();
      end
      dbg_req = 0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset_during_read();
      dbg_req = 1; dbg_we = 0; dbg_addr = 11'h005;
      #2;
      checks++;
      if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rstrd_gnt: got %b, required 1", dbg_gnt); end
      next_cycle();
      dbg_req = 0; reset = 1;
      #2;
      checks += 2;
      if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_rvalid: got %b, required 0", dbg_rvalid); end
      if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL rstrd_rdata: got %h, required 0000", dbg_rdata); end
      next_cycle();
      reset = 0;
      #2;
      checks += 2;
      if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_rvalid_after: got %b, required 0", dbg_rvalid); end
      if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL rstrd_rdata_after: got %h, required 0000", dbg_rdata); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_cpu_write_dbg_read();
      test_starvation();
      test_rw_both();
      test_burst();
      test_reset_during_read();
      next_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending returns, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
